// File: rtl/cache_mem_responder_if.sv
// Handshaked line-request port between cache_control (master) and the memory responder (slave).
interface cache_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        wr_done;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, wr_valid, wr_data, rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, wr_done, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, wr_valid, wr_data, rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, wr_done, busy
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Slow-memory model: serves one cache line at a time as a burst of 16-bit beats
// from an internal halfword array, with a programmable access delay.
module cache_mem_responder #(
    parameter int DEPTH   = 4096,
    parameter int BEATS   = 8,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cache_mem_responder_if.slave   bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = $clog2(BEATS);
    localparam int CW     = $clog2(LATENCY + 1) + 1;
    localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [CW-1:0] RD_CNT_END = CW'(LATENCY);
    localparam logic [CW-1:0] WR_CNT_END = CW'(LAT_M1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_WAIT, WR_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   beat_addr;
    logic            wr_en;
    logic            unused_addr_bits;

    // Power-of-two DEPTH: truncating the sum gives the wrap past DEPTH-1.
    assign beat_addr        = base_q + AW'(beat_q);
    assign wr_en            = (state_q == WR_BEAT) && bus.wr_valid;
    assign unused_addr_bits = ^{bus.req_addr[31:AW+1], bus.req_addr[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    base_d  = bus.req_addr[AW:1];
                    beat_d  = '0;
                    cnt_d   = '0;
                    state_d = bus.req_write ? WR_BEAT : RD_WAIT;
                end
            end
            // Waits LATENCY+1 cycles so LATENCY=0 still gives one cycle of access time.
            RD_WAIT: begin
                if (cnt_q == RD_CNT_END) state_d = RD_BEAT;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            RD_BEAT: begin
                if (bus.rd_ready) begin
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                    else                     beat_d  = beat_q + 1'b1;
                end
            end
            WR_BEAT: begin
                if (bus.wr_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = (LATENCY == 0) ? WR_RESP : WR_WAIT;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                if (cnt_q == WR_CNT_END) state_d = WR_RESP;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            WR_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[beat_addr] <= bus.wr_data;
    end

    // All outputs decode the registered state, so reset clears them at once.
    assign bus.busy      = (state_q != IDLE);
    assign bus.req_ready = (state_q == IDLE);
    assign bus.wr_ready  = (state_q == WR_BEAT);
    assign bus.rd_valid  = (state_q == RD_BEAT);
    assign bus.rd_data   = (state_q == RD_BEAT) ? mem[beat_addr] : 16'h0000;
    assign bus.rd_last   = (state_q == RD_BEAT) && (beat_q == LAST_BEAT);
    assign bus.wr_done   = (state_q == WR_RESP);
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: timing, data, stalls, wrap, request
// blocking and mid-burst reset, with hand-computed expectations.
module tb_cache_mem_responder;
    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cache_mem_responder_if bus ();

    cache_mem_responder #(.DEPTH(4096), .BEATS(8), .LATENCY(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic read_burst(input logic [31:0] addr, input logic [31:0] rdy_pat,
                              output logic [7:0][15:0] data, output logic [7:0] last_mask,
                              output int first_lat, output int held_bad, output bit timeout);
        int k, n, vcyc;
        logic [15:0] prev;
        bit stalled;
        data = '0; last_mask = '0; first_lat = -1; held_bad = 0; timeout = 0;
        n = 0; vcyc = 0; stalled = 0; prev = '0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = 0; bus.req_addr = addr; bus.rd_ready = 0;
        @(negedge clk);
        bus.req_valid = 0;
        k = 0;
        while (n < 8 && k < 100) begin
            if (bus.rd_valid) begin
                if (first_lat < 0) first_lat = k;
                if (stalled && bus.rd_data !== prev) held_bad++;
                prev = bus.rd_data;
                bus.rd_ready = rdy_pat[vcyc % 32];
                vcyc++;
                stalled = !bus.rd_ready;
                if (bus.rd_ready) begin
                    data[n] = bus.rd_data;
                    last_mask[n] = bus.rd_last;
                    n++;
                end
            end else begin
                bus.rd_ready = 0;
            end
            @(negedge clk);
            k++;
        end
        bus.rd_ready = 0;
        timeout = (n < 8);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0][15:0] data,
                               input int gap_after, input int gap_len,
                               output int done_lat, output logic wr_rdy1, output bit timeout);
        int i, g, k;
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = 1; bus.req_addr = addr;
        @(negedge clk);
        bus.req_valid = 0; bus.req_write = 0;
        i = 0; g = 0; k = 0;
        while (i < 8 && k < 100) begin
            if (i == gap_after && g < gap_len) begin
                bus.wr_valid = 0; g++;
            end else if (bus.wr_ready) begin
                bus.wr_valid = 1; bus.wr_data = data[i]; i++;
            end else begin
                bus.wr_valid = 0;
            end
            if (i < 8) begin @(negedge clk); k++; end
        end
        done_lat = -1; wr_rdy1 = 1'bx;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            bus.wr_valid = 0;
            if (j == 1) wr_rdy1 = bus.wr_ready;
            if (bus.wr_done) begin done_lat = j; break; end
        end
        timeout = (i < 8) || (done_lat < 0);
    endtask

    task automatic test_reset;
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0;
        bus.wr_valid = 0; bus.wr_data = '0; bus.rd_ready = 0;
        reset_n = 0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got=%h exp=0000", bus.rd_data); end
        checks++; if (bus.rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got=%b exp=0", bus.rd_last); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%b exp=0", bus.wr_ready); end
        checks++; if (bus.wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done got=%b exp=0", bus.wr_done); end
        reset_n = 1;
    endtask

    task automatic test_read_basic;
        logic [7:0][15:0] wd, rd;
        logic [7:0] lm;
        int lat, held, dl;
        logic r1;
        bit to;
        // mem[800..807] is preloaded through the write port.
        for (int i = 0; i < 8; i++) wd[i] = 16'(16'h0100 + i);
        write_burst(32'd1600, wd, 99, 0, dl, r1, to);
        read_burst(32'd1600, 32'hFFFF_FFFF, rd, lm, lat, held, to);
        checks++; if (to) begin errors++; $display("FAIL rd_basic_timeout got=timeout exp=8 beats"); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_basic_first_lat got=%0d exp=3", lat); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rd[i] !== wd[i]) begin errors++; $display("FAIL rd_basic_beat%0d got=%h exp=%h", i, rd[i], wd[i]); end
        end
        checks++; if (lm !== 8'h80) begin errors++; $display("FAIL rd_basic_last_mask got=%h exp=80", lm); end
        checks++; if (bus.rd_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_basic_idle got=rv%b rr%b exp=rv0 rr1", bus.rd_valid, bus.req_ready); end
    endtask

    task automatic test_write;
        logic [7:0][15:0] wd, rd;
        logic [7:0] lm;
        int lat, held, dl;
        logic r1;
        bit to;
        for (int i = 0; i < 8; i++) wd[i] = 16'(16'hAA01 + i);
        write_burst(32'd2624, wd, 4, 2, dl, r1, to);
        checks++; if (to) begin errors++; $display("FAIL wr_timeout got=timeout exp=wr_done"); end
        checks++; if (dl !== 3) begin errors++; $display("FAIL wr_done_lat got=%0d exp=3", dl); end
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL wr_ready_after_last got=%b exp=0", r1); end
        @(negedge clk);
        checks++; if (bus.wr_done !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL wr_done_pulse got=wd%b rr%b exp=wd0 rr1", bus.wr_done, bus.req_ready); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (dut.mem[1312+i] !== wd[i]) begin
                errors++; $display("FAIL wr_mem%0d got=%h exp=%h", 1312+i, dut.mem[1312+i], wd[i]); end
        end
        read_burst(32'd2624, 32'hFFFF_FFFF, rd, lm, lat, held, to);
        checks++; if (to || rd !== wd) begin errors++; $display("FAIL wr_readback got=%h exp=%h", rd, wd); end
    endtask

    task automatic test_stall;
        logic [7:0][15:0] rd, exp_d;
        logic [7:0] lm;
        int lat, held;
        bit to;
        for (int i = 0; i < 8; i++) exp_d[i] = 16'(16'h0100 + i);
        read_burst(32'd1600, 32'hFFFF_FFF9, rd, lm, lat, held, to);
        checks++; if (to) begin errors++; $display("FAIL stall_timeout got=timeout exp=8 beats"); end
        checks++; if (held !== 0) begin errors++; $display("FAIL stall_hold got=%0d changes exp=0", held); end
        checks++; if (rd !== exp_d) begin errors++; $display("FAIL stall_data got=%h exp=%h", rd, exp_d); end
        checks++; if (lm !== 8'h80) begin errors++; $display("FAIL stall_last_mask got=%h exp=80", lm); end
    endtask

    task automatic test_wrap;
        logic [7:0][15:0] wd, rd;
        logic [7:0] lm;
        int lat, held, dl;
        logic r1;
        bit to;
        for (int i = 0; i < 8; i++) wd[i] = 16'(16'hC000 + i);
        write_burst(32'd8188, wd, 99, 0, dl, r1, to);
        checks++; if (dut.mem[4095] !== 16'hC001) begin errors++; $display("FAIL wrap_mem4095 got=%h exp=c001", dut.mem[4095]); end
        checks++; if (dut.mem[0] !== 16'hC002) begin errors++; $display("FAIL wrap_mem0 got=%h exp=c002", dut.mem[0]); end
        checks++; if (dut.mem[5] !== 16'hC007) begin errors++; $display("FAIL wrap_mem5 got=%h exp=c007", dut.mem[5]); end
        read_burst(32'd8188, 32'hFFFF_FFFF, rd, lm, lat, held, to);
        checks++; if (to || rd !== wd) begin errors++; $display("FAIL wrap_read got=%h exp=%h", rd, wd); end
    endtask

    task automatic test_req_ignored;
        int k, n, rr_bad;
        logic [15:0] first1, first2;
        bit done;
        first1 = 'x; first2 = 'x;
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'd2624; bus.rd_ready = 0;
        @(negedge clk);
        bus.req_addr = 32'd1600;
        n = 0; k = 0; rr_bad = 0;
        while (n < 8 && k < 100) begin
            if (bus.req_ready !== 1'b0) rr_bad++;
            if (bus.rd_valid) begin
                if (n == 0) first1 = bus.rd_data;
                bus.rd_ready = 1; n++;
            end else begin
                bus.rd_ready = 0;
            end
            @(negedge clk); k++;
        end
        bus.rd_ready = 0;
        checks++; if (rr_bad !== 0 || n != 8) begin errors++; $display("FAIL blk_req_ready got=%0d bad/%0d beats exp=0/8", rr_bad, n); end
        checks++; if (first1 !== 16'hAA01) begin errors++; $display("FAIL blk_first_data got=%h exp=aa01", first1); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL blk_idle got=%b exp=1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL blk_accept_later got=%b exp=1", bus.busy); end
        for (int j = 0; j < 20; j++) begin
            if (bus.rd_valid) begin first2 = bus.rd_data; break; end
            @(negedge clk);
        end
        checks++; if (first2 !== 16'h0100) begin errors++; $display("FAIL blk_second_data got=%h exp=0100", first2); end
        bus.rd_ready = 1; done = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (bus.req_ready) begin done = 1; break; end
        end
        bus.rd_ready = 0;
        checks++; if (!done) begin errors++; $display("FAIL blk_drain got=timeout exp=idle"); end
    endtask

    task automatic test_reset_mid_write;
        logic [7:0][15:0] wd;
        int dl;
        logic r1;
        bit to;
        for (int i = 0; i < 8; i++) wd[i] = 16'(16'h5500 + i);
        write_burst(32'd3000, wd, 99, 0, dl, r1, to);
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 32'd3000;
        @(negedge clk);
        bus.req_valid = 0; bus.req_write = 0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1; bus.wr_data = 16'(16'hBB01 + i);
            @(negedge clk);
        end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got=%b exp=1", bus.wr_ready); end
        bus.wr_data = 16'hBB04;
        #1 reset_n = 0;
        #1;
        checks++; if (bus.wr_ready !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got=wr%b rr%b bz%b exp=wr0 rr1 bz0", bus.wr_ready, bus.req_ready, bus.busy); end
        @(negedge clk);
        bus.wr_valid = 0;
        reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] e;
            e = (i < 3) ? 16'(16'hBB01 + i) : wd[i];
            checks++; if (dut.mem[1500+i] !== e) begin
                errors++; $display("FAIL rst_mid_mem%0d got=%h exp=%h", 1500+i, dut.mem[1500+i], e); end
        end
    endtask

    initial begin
        test_reset;
        test_read_basic;
        test_write;
        test_stall;
        test_wrap;
        test_req_ignored;
        test_reset_mid_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
